// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - AD7928-style 8-channel 12-bit ADC SPI slave emulator
// Optional build macro: ADC_RESP_CODING_EN (honours the CODING bit, ctrl_reg[4])
module adc_spi_responder #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int RESET_ADDR  = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     spi_cs_n,
    input  logic                     spi_sclk,
    input  logic                     spi_din,
    output logic                     spi_dout,
    output logic                     spi_dout_oe,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [15:0]              ctrl_reg,
    output logic                     frame_done,
    output logic                     frame_err
);

    // Control word after reset: WEN=0, address RESET_ADDR, PM=11, RANGE/CODING=11
    localparam logic [15:0] CTRL_RST =
        {1'b0, 2'b00, 3'(RESET_ADDR), 2'b11, 2'b00, 2'b11, 4'h0};
    localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [4:0] FRAME_BITS = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   cs_q;
    logic                   sclk_q;

    logic cs_s;
    logic sclk_s;
    logic din_s;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    logic [15:0]       shift_tx;
    logic [15:0]       shift_rx;
    logic [4:0]        bit_cnt;
    logic              fall_pend;
    logic              start;
    logic              wr_ctrl;

    logic [2:0]        cur_addr;
    logic [DATA_W-1:0] samp;
    logic              addr_ok;
    logic [DATA_W-1:0] data_field;
    logic [15:0]       tx_word;

    // Synchronise the SPI pins; the cs_n chain resets low so that a frame
    // already running when reset is released never produces a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            din_sync  <= '0;
            cs_q      <= 1'b0;
            sclk_q    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], spi_din};
            cs_q      <= cs_sync[SYNC_STAGES-1];
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    // Edge strobes from the synchronised level against its delayed copy
    always_comb begin
        cs_s      = cs_sync[SYNC_STAGES-1];
        sclk_s    = sclk_sync[SYNC_STAGES-1];
        din_s     = din_sync[SYNC_STAGES-1];
        cs_fall   = cs_q & ~cs_s;
        cs_rise   = ~cs_q & cs_s;
        sclk_rise = ~sclk_q & sclk_s;
        sclk_fall = sclk_q & ~sclk_s;
    end

    // Select the sample for the address held in the control register
    always_comb begin
        cur_addr = ctrl_reg[12:10];
        samp     = '0;
        addr_ok  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_addr == 3'(k)) begin
                samp    = ch_data[k*DATA_W +: DATA_W];
                addr_ok = 1'b1;
            end
        end
    end

    // Build the outgoing frame: leading zero, echoed address, data field
    always_comb begin
        data_field = '0;
        if (addr_ok) begin
`ifdef ADC_RESP_CODING_EN
            data_field = ctrl_reg[4] ? samp : (samp ^ SIGN_BIT);
`else
            data_field = samp;
`endif
        end
        tx_word = {1'b0, cur_addr, data_field};
    end

    // Frame state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and frame-status outputs
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        spi_dout_oe = 1'b0;
        frame_done  = 1'b0;
        frame_err   = 1'b0;
        wr_ctrl     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall || fall_pend) begin
                    start     = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                spi_dout_oe = 1'b1;
                if (cs_rise) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bit_cnt == FRAME_BITS) begin
                    frame_done = 1'b1;
                    wr_ctrl    = shift_rx[15];
                end else begin
                    frame_err  = 1'b1;
                end
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and DOUT; a cs_n edge in the same clk as
    // an sclk edge takes priority and the sclk edge is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_tx  <= '0;
            shift_rx  <= '0;
            bit_cnt   <= '0;
            spi_dout  <= 1'b0;
            fall_pend <= 1'b0;
        end else begin
            fall_pend <= (state == ST_DONE) && cs_fall;
            case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    spi_dout <= 1'b0;
                    if (start) begin
                        shift_tx <= tx_word;
                        shift_rx <= '0;
                        spi_dout <= tx_word[15];
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        spi_dout <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            shift_rx <= {shift_rx[14:0], din_s};
                            if (bit_cnt != 5'd31) begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        if (sclk_fall) begin
                            shift_tx <= {shift_tx[14:0], 1'b0};
                            spi_dout <= shift_tx[14];
                        end
                    end
                end
                ST_DONE: begin
                    spi_dout <= 1'b0;
                end
                default: begin
                    spi_dout <= 1'b0;
                end
            endcase
        end
    end

    // Control register: only a complete 16-bit frame with WEN set updates it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg <= CTRL_RST;
        end else if (wr_ctrl) begin
            ctrl_reg <= shift_rx;
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed self-checking bench for adc_spi_responder
module tb_adc_spi_responder;

    logic         clk;
    logic         reset_n;
    logic         spi_cs_n;
    logic         spi_sclk;
    logic         spi_din;
    logic         spi_dout;
    logic         spi_dout_oe;
    logic [95:0]  ch_data;
    logic [15:0]  ctrl_reg;
    logic         frame_done;
    logic         frame_err;

    int n_cmp;
    int n_err;
    int done_cnt;
    int err_cnt;
    logic oe_at_end;

    adc_spi_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_din    (spi_din),
        .spi_dout   (spi_dout),
        .spi_dout_oe(spi_dout_oe),
        .ch_data    (ch_data),
        .ctrl_reg   (ctrl_reg),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
        if (frame_done || frame_err) oe_at_end <= spi_dout_oe;
    end

    task automatic sclk_pulse(input logic [15:0] w, input int i, inout logic [15:0] dw);
        int j;
        if (i < 16) dw[15-i] = spi_dout;
        spi_sclk = 1'b1;
        repeat (10) @(negedge clk);
        spi_sclk = 1'b0;
        j = 14 - i;
        spi_din = (j >= 0) ? w[j] : 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_frame(input logic [15:0] w, input int nbits, input int gap,
                            output logic [15:0] dw, output logic oe_mid);
        dw = '0;
        oe_mid = 1'b0;
        spi_cs_n = 1'b0;
        spi_din = w[15];
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == 8) oe_mid = spi_dout_oe;
            sclk_pulse(w, i, dw);
        end
        spi_cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        n_cmp++; if (spi_dout !== 1'b0) begin n_err++; $display("FAIL rst_dout: got %b expected 0", spi_dout); end
        n_cmp++; if (spi_dout_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b expected 0", spi_dout_oe); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", frame_done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", frame_err); end
        n_cmp++; if (ctrl_reg !== 16'h0330) begin n_err++; $display("FAIL rst_ctrl: got %h expected 0330", ctrl_reg); end
    endtask

    task automatic test_write;
        logic [15:0] d;
        logic oe;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        do_frame(16'h8330, 16, 10, d, oe);
        n_cmp++; if (d !== 16'h0ABC) begin n_err++; $display("FAIL t1_dout: got %h expected 0abc", d); end
        n_cmp++; if (oe !== 1'b1) begin n_err++; $display("FAIL t1_oe_mid: got %b expected 1", oe); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL t1_done: got %0d expected 1", done_cnt - d0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_err++; $display("FAIL t1_err: got %0d expected 0", err_cnt - e0); end
        n_cmp++; if (ctrl_reg !== 16'h8330) begin n_err++; $display("FAIL t1_ctrl: got %h expected 8330", ctrl_reg); end
    endtask

    task automatic test_pipelined;
        logic [15:0] d;
        logic oe;
        do_frame(16'h8730, 16, 10, d, oe);
        n_cmp++; if (d !== 16'h0ABC) begin n_err++; $display("FAIL t2_dout_a: got %h expected 0abc", d); end
        n_cmp++; if (ctrl_reg !== 16'h8730) begin n_err++; $display("FAIL t2_ctrl: got %h expected 8730", ctrl_reg); end
        do_frame(16'h8730, 16, 10, d, oe);
        n_cmp++; if (d !== 16'h1123) begin n_err++; $display("FAIL t2_dout_b: got %h expected 1123", d); end
    endtask

    task automatic test_no_wen;
        logic [15:0] d;
        logic oe;
        do_frame(16'h0330, 16, 10, d, oe);
        n_cmp++; if (ctrl_reg !== 16'h8730) begin n_err++; $display("FAIL t3_ctrl: got %h expected 8730", ctrl_reg); end
        do_frame(16'h0330, 16, 10, d, oe);
        n_cmp++; if (d !== 16'h1123) begin n_err++; $display("FAIL t3_dout: got %h expected 1123", d); end
    endtask

    task automatic test_short_frame;
        logic [15:0] d;
        logic oe;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        oe_at_end = 1'b1;
        do_frame(16'h8330, 8, 10, d, oe);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_err++; $display("FAIL t4_err: got %0d expected 1", err_cnt - e0); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL t4_done: got %0d expected 0", done_cnt - d0); end
        n_cmp++; if (oe_at_end !== 1'b0) begin n_err++; $display("FAIL t4_oe_done: got %b expected 0", oe_at_end); end
        n_cmp++; if (ctrl_reg !== 16'h8730) begin n_err++; $display("FAIL t4_ctrl: got %h expected 8730", ctrl_reg); end
        do_frame(16'h0330, 16, 10, d, oe);
        n_cmp++; if (d !== 16'h1123) begin n_err++; $display("FAIL t4_recover: got %h expected 1123", d); end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] d;
        logic [15:0] w;
        logic oe;
        int d0, e0;
        w = 16'h8730;
        d = '0;
        spi_cs_n = 1'b0;
        spi_din = w[15];
        repeat (10) @(negedge clk);
        for (int i = 0; i < 7; i++) sclk_pulse(w, i, d);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (spi_dout !== 1'b0) begin n_err++; $display("FAIL t5_dout: got %b expected 0", spi_dout); end
        n_cmp++; if (spi_dout_oe !== 1'b0) begin n_err++; $display("FAIL t5_oe: got %b expected 0", spi_dout_oe); end
        n_cmp++; if (ctrl_reg !== 16'h0330) begin n_err++; $display("FAIL t5_ctrl_rst: got %h expected 0330", ctrl_reg); end
        n_cmp++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin n_err++; $display("FAIL t5_pulses: got %b%b expected 00", frame_done, frame_err); end
        reset_n = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 7; i < 16; i++) sclk_pulse(w, i, d);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin n_err++; $display("FAIL t5_ignored: got done %0d err %0d expected 0 0", done_cnt - d0, err_cnt - e0); end
        n_cmp++; if (ctrl_reg !== 16'h0330) begin n_err++; $display("FAIL t5_ctrl_after: got %h expected 0330", ctrl_reg); end
        do_frame(16'h0330, 16, 10, d, oe);
        n_cmp++; if (d !== 16'h0ABC) begin n_err++; $display("FAIL t5_dout_next: got %h expected 0abc", d); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        logic oe;
        int d0;
        d0 = done_cnt;
        do_frame(16'h8730, 16, 1, d, oe);
        n_cmp++; if (d !== 16'h0ABC) begin n_err++; $display("FAIL b2b_dout_a: got %h expected 0abc", d); end
        do_frame(16'h8330, 16, 10, d, oe);
        n_cmp++; if (d !== 16'h1123) begin n_err++; $display("FAIL b2b_dout_b: got %h expected 1123", d); end
        n_cmp++; if (done_cnt - d0 !== 2) begin n_err++; $display("FAIL b2b_done: got %0d expected 2", done_cnt - d0); end
        n_cmp++; if (ctrl_reg !== 16'h8330) begin n_err++; $display("FAIL b2b_ctrl: got %h expected 8330", ctrl_reg); end
    endtask

    task automatic test_coding;
        logic [15:0] d;
        logic [15:0] exp_d;
        logic oe;
`ifdef ADC_RESP_CODING_EN
        exp_d = 16'h02BC;
`else
        exp_d = 16'h0ABC;
`endif
        do_frame(16'h8320, 16, 10, d, oe);
        n_cmp++; if (d !== 16'h0ABC) begin n_err++; $display("FAIL t6_dout_a: got %h expected 0abc", d); end
        n_cmp++; if (ctrl_reg !== 16'h8320) begin n_err++; $display("FAIL t6_ctrl: got %h expected 8320", ctrl_reg); end
        do_frame(16'h0330, 16, 10, d, oe);
        n_cmp++; if (d !== exp_d) begin n_err++; $display("FAIL t6_dout_b: got %h expected %h", d, exp_d); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        done_cnt = 0;
        err_cnt = 0;
        oe_at_end = 1'b0;
        reset_n = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_din = 1'b0;
        ch_data = '0;
        ch_data[11:0]  = 12'hABC;
        ch_data[23:12] = 12'h123;
        ch_data[35:24] = 12'h456;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_write();
        test_pipelined();
        test_no_wen();
        test_short_frame();
        test_reset_mid_frame();
        test_back_to_back();
        test_coding();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
